vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACT, default 640, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch in clocks.
REQ-003 Parameter V_ACT, default 480, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch in lines.
REQ-005 Parameter H_POL / V_POL, default 0 / 0, active level of the sync pulse.
REQ-006 Parameter DW, default 8, bits per colour channel.
REQ-007 Parameter PIX_LAT, default 2, range 1..8, clocks from oREAD_Request to returned pixel data.
REQ-008 Parameter V_MARK, default 9, leading active lines forced black with no request issued.
REQ-009 Port iCLK, in, 1, pixel clock; the block has one clock and reset is synchronous and active-high.
REQ-010 Port iRST, in, 1, synchronous active-high reset.
REQ-011 Port iEN, in, 1, run enable.
REQ-012 Port iRed / iGreen / iBlue, in, DW each, returned pixel data.
REQ-013 Port iData_Valid, in, 1, returned data valid, qualified PIX_LAT clocks after the request.
REQ-014 Port oREAD_Request, out, 1, one pixel fetch per asserted clock.
REQ-015 Port oX / oY, out, 16 each, coordinates of the pixel being requested.
REQ-016 Port oVGA_R / oVGA_G / oVGA_B, out, DW each, pixel output.
REQ-017 Port oVGA_H_SYNC / oVGA_V_SYNC, out, 1 each, sync outputs.
REQ-018 Port oVGA_BLANK, out, 1, high during active video.
REQ-019 Port oFrame_Start, out, 1, one-clock pulse.
REQ-020 Port oUnderflow, out, 1, sticky data-underflow flag.

Function
REQ-021 H counter SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACT+H_FP+H_SYNC+H_BP), wrap to 0, and increment the V counter on wrap; V counter SHALL wrap at V_TOTAL-1 to 0.
REQ-022 Region order SHALL be active, then front porch, sync, back porch, on both axes.
REQ-023 Sync SHALL be at POL level for H in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC), else at ~POL; V likewise by line.
REQ-024 oREAD_Request SHALL be 1 iff H<H_ACT and V_MARK<=V<V_ACT and iEN=1; oX/oY = current H/V.
REQ-025 Sync, blank and active-region flags SHALL pass through a PIX_LAT-deep delay line so they align with the returned data.
REQ-026 oVGA_R/G/B SHALL equal the input data when the delayed request flag=1 and iData_Valid=1, else 0.
REQ-027 Delayed request=1 with iData_Valid=0 SHALL output black and set oUnderflow.
REQ-028 oUnderflow SHALL clear only on reset or on the oFrame_Start clock, where a simultaneous set SHALL win.
REQ-029 oFrame_Start SHALL pulse on the delayed output stage when H=0 and V=0.
REQ-030 iEN=0 SHALL hold both counters at 0 and drive the delay-line input as idle; in-flight stages SHALL drain normally.
REQ-031 Lines V<V_MARK inside the active region SHALL drive oVGA_BLANK=1 with black output.

Reset
REQ-032 On iRST: counters=0, delay line idle, oREAD_Request=0, oVGA_R/G/B=0, syncs=~POL, oVGA_BLANK=0, oFrame_Start=0, oUnderflow=0.
REQ-033 Reset mid-frame SHALL restart timing at H=0,V=0 on the first clock after iRST falls.

Structure
REQ-034 Default timing constants and H_TOTAL/V_TOTAL derivation SHALL live in shared package vga_timing_pkg.
REQ-035 The delay line SHALL be sub-module vga_delay_line (parametrised width and depth).

Verification
REQ-036 Reset then run 1 frame at defaults -> H period 800 clocks, V period 525 lines, hsync low for 96 clocks starting at H=656.
REQ-037 Count requests over a frame -> 640*(480-9)=301440; first request at V=9, H=0.
REQ-038 PIX_LAT=3, iData_Valid=1 with data = request index -> first output pixel appears 3 clocks after first request, with oVGA_BLANK=1.
REQ-039 Drop iData_Valid for one expected clock -> that pixel is black and oUnderflow=1 until the next oFrame_Start.
REQ-040 Assert iRST at H=300,V=200 -> all outputs at reset values; timing restarts at H=0,V=0.
REQ-041 H_POL=1, V_POL=1 -> syncs idle low with high pulses of the same widths and positions.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the control bundle that rides the pixel delay line.
package vga_timing_pkg;

  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic req;
    logic fs;
  } pix_ctl_t;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; resets every stage to a caller-chosen idle word.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with pixel fetch requests; sync/blank are delayed
// to line up with pixel data returned PIX_LAT clocks after each request.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0,
  parameter int DW      = 8,
  parameter int PIX_LAT = 2,
  parameter int V_MARK  = 9
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iEN,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic          iData_Valid,
  output logic          oREAD_Request,
  output logic [15:0]   oX,
  output logic [15:0]   oY,
  output logic [DW-1:0] oVGA_R,
  output logic [DW-1:0] oVGA_G,
  output logic [DW-1:0] oVGA_B,
  output logic          oVGA_H_SYNC,
  output logic          oVGA_V_SYNC,
  output logic          oVGA_BLANK,
  output logic          oFrame_Start,
  output logic          oUnderflow
);

  localparam int H_TOTAL = axis_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACT, V_FP, V_SYNC, V_BP);

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_END  = 16'(H_ACT);
  localparam logic [15:0] HS_LO  = 16'(H_ACT + H_FP);
  localparam logic [15:0] HS_HI  = 16'(H_ACT + H_FP + H_SYNC);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_END  = 16'(V_ACT);
  localparam logic [15:0] VS_LO  = 16'(V_ACT + V_FP);
  localparam logic [15:0] VS_HI  = 16'(V_ACT + V_FP + V_SYNC);
  localparam logic [15:0] V_MK   = 16'(V_MARK);

  localparam pix_ctl_t IDLE = '{
    hs: ~H_POL, vs: ~V_POL, act: 1'b0, req: 1'b0, fs: 1'b0
  };

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  pix_ctl_t    ctl_in;
  pix_ctl_t    ctl_out;
  logic        unf;
  logic        pix_ok;

  always_ff @(posedge iCLK) begin
    if (iRST || !iEN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  always_comb begin
    ctl_in = IDLE;
    if (!iRST && iEN) begin
      ctl_in.hs  = (h_cnt >= HS_LO && h_cnt < HS_HI) ? H_POL : ~H_POL;
      ctl_in.vs  = (v_cnt >= VS_LO && v_cnt < VS_HI) ? V_POL : ~V_POL;
      ctl_in.act = (h_cnt < H_END) && (v_cnt < V_END);
      ctl_in.req = ctl_in.act && (v_cnt >= V_MK);
      ctl_in.fs  = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    end
  end

  assign oREAD_Request = ctl_in.req;
  assign oX            = h_cnt;
  assign oY            = v_cnt;

  vga_delay_line #(
    .W       ($bits(pix_ctl_t)),
    .DEPTH   (PIX_LAT),
    .RST_VAL (IDLE)
  ) u_dly (
    .clk (iCLK),
    .rst (iRST),
    .d   (ctl_in),
    .q   (ctl_out)
  );

  assign pix_ok = ctl_out.req && iData_Valid;

  // a late pixel in the same frame-start clock still counts as an underflow
  always_ff @(posedge iCLK) begin
    if (iRST)                            unf <= 1'b0;
    else if (ctl_out.req && !iData_Valid) unf <= 1'b1;
    else if (ctl_out.fs)                 unf <= 1'b0;
  end

  assign oVGA_R       = pix_ok ? iRed   : '0;
  assign oVGA_G       = pix_ok ? iGreen : '0;
  assign oVGA_B       = pix_ok ? iBlue  : '0;
  assign oVGA_H_SYNC  = ctl_out.hs;
  assign oVGA_V_SYNC  = ctl_out.vs;
  assign oVGA_BLANK   = ctl_out.act;
  assign oFrame_Start = ctl_out.fs;
  assign oUnderflow   = unf;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small raster (24x17, PIX_LAT=3) plus a default-size
// raster with inverted sync polarity.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] red, green, blue;
  logic       valid;

  logic        req_a, hs_a, vs_a, blank_a, fs_a, unf_a;
  logic [15:0] x_a, y_a;
  logic [7:0]  r_a, g_a, b_a;

  logic        req_b, hs_b, vs_b, blank_b, fs_b, unf_b;
  logic [15:0] x_b, y_b;
  logic [7:0]  r_b, g_b, b_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .DW(8), .PIX_LAT(3), .V_MARK(2)
  ) dut_a (
    .iCLK(clk), .iRST(rst), .iEN(en),
    .iRed(red), .iGreen(green), .iBlue(blue), .iData_Valid(valid),
    .oREAD_Request(req_a), .oX(x_a), .oY(y_a),
    .oVGA_R(r_a), .oVGA_G(g_a), .oVGA_B(b_a),
    .oVGA_H_SYNC(hs_a), .oVGA_V_SYNC(vs_a), .oVGA_BLANK(blank_a),
    .oFrame_Start(fs_a), .oUnderflow(unf_a)
  );

  vga_timing_gen #(
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .iCLK(clk), .iRST(rst), .iEN(en),
    .iRed(red), .iGreen(green), .iBlue(blue), .iData_Valid(valid),
    .oREAD_Request(req_b), .oX(x_b), .oY(y_b),
    .oVGA_R(r_b), .oVGA_G(g_b), .oVGA_B(b_b),
    .oVGA_H_SYNC(hs_b), .oVGA_V_SYNC(vs_b), .oVGA_BLANK(blank_b),
    .oFrame_Start(fs_b), .oUnderflow(unf_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  logic [7:0] dq [512];
  bit         dreq [512];

  int idx = 0, first_req = -1, hs_lo = 0, first_hs = -1;
  int vs_lo = 0, first_vs = -1, fs_n = 0, rsum = 0;
  int first_px = -1, px_blank = 0, px_val = 0;
  int hb = 0, first_hb = -1, vb = 0;
  int found = 0;

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b1;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req",   int'(req_a),   0);
    check("rst_hs",    int'(hs_a),    1);
    check("rst_vs",    int'(vs_a),    1);
    check("rst_blank", int'(blank_a), 0);
    check("rst_fs",    int'(fs_a),    0);
    check("rst_unf",   int'(unf_a),   0);
    check("rst_r",     int'(r_a),     0);
    check("rst_x",     int'(x_a),     0);
    check("rst_hs_b",  int'(hs_b),    0);
    check("rst_vs_b",  int'(vs_b),    0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7210; k++) begin
      red   = (k < 512 && dreq[k]) ? dq[k] : 8'd0;
      green = ~red;
      blue  = red;
      valid = (k != 79);
      #1;
      if (k < 416) begin
        if (req_a) begin
          if (first_req < 0) first_req = k;
          dq[k+3]   = 8'(idx + 1);
          dreq[k+3] = 1'b1;
          idx++;
        end
        if (!hs_a) begin
          hs_lo++;
          if (first_hs < 0) first_hs = k;
        end
        if (!vs_a) begin
          vs_lo++;
          if (first_vs < 0) first_vs = k;
        end
        if (fs_a) fs_n++;
        rsum += int'(r_a);
        if (r_a != 8'd0 && first_px < 0) begin
          first_px = k;
          px_blank = int'(blank_a);
          px_val   = int'(r_a);
        end
        case (k)
          2: check("blank_k2", int'(blank_a), 0);
          3: begin
            check("blank_k3", int'(blank_a), 1);
            check("mark_r_k3", int'(r_a), 0);
            check("fs_k3", int'(fs_a), 1);
          end
          23: begin
            check("x_k23", int'(x_a), 23);
            check("y_k23", int'(y_a), 0);
          end
          24: begin
            check("x_k24", int'(x_a), 0);
            check("y_k24", int'(y_a), 1);
          end
          79: begin
            check("drop_r", int'(r_a), 0);
            check("unf_k79", int'(unf_a), 0);
          end
          80:  check("unf_k80", int'(unf_a), 1);
          407: begin
            check("x_k407", int'(x_a), 23);
            check("y_k407", int'(y_a), 16);
          end
          408: begin
            check("x_wrap", int'(x_a), 0);
            check("y_wrap", int'(y_a), 0);
          end
          411: check("unf_k411", int'(unf_a), 1);
          412: check("unf_k412", int'(unf_a), 0);
          default: ;
        endcase
      end
      if (k < 800 && hs_b) hb++;
      if (hs_b && first_hb < 0) first_hb = k;
      if (vs_b) vb++;
      case (k)
        1457: check("hs_b_k1457", int'(hs_b), 0);
        1458: check("hs_b_k1458", int'(hs_b), 1);
        7199: check("req_b_k7199", int'(req_b), 0);
        7200: begin
          check("req_b_k7200", int'(req_b), 1);
          check("x_b_k7200", int'(x_b), 0);
          check("y_b_k7200", int'(y_b), 9);
        end
        default: ;
      endcase
      @(negedge clk);
    end

    check("req_count",  idx,       160);
    check("first_req",  first_req, 48);
    check("hs_lo_n",    hs_lo,     51);
    check("first_hs",   first_hs,  21);
    check("vs_lo_n",    vs_lo,     48);
    check("first_vs",   first_vs,  315);
    check("fs_n",       fs_n,      2);
    check("first_px",   first_px,  51);
    check("px_blank",   px_blank,  1);
    check("px_val",     px_val,    1);
    check("rsum",       rsum,      12859);
    check("hs_b_n",     hb,        96);
    check("first_hs_b", first_hb,  658);
    check("vs_b_n",     vb,        0);

    valid = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      @(negedge clk);
      #1;
      if (x_a == 16'd10 && y_a == 16'd5) found = 1;
    end
    check("mid_find", found, 1);
    check("unf_pre", int'(unf_a), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_req",   int'(req_a),   0);
    check("mid_x",     int'(x_a),     0);
    check("mid_y",     int'(y_a),     0);
    check("mid_hs",    int'(hs_a),    1);
    check("mid_vs",    int'(vs_a),    1);
    check("mid_blank", int'(blank_a), 0);
    check("mid_fs",    int'(fs_a),    0);
    check("mid_unf",   int'(unf_a),   0);
    check("mid_r",     int'(r_a),     0);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b1;
    #1;
    check("restart_x0", int'(x_a), 0);
    check("restart_y0", int'(y_a), 0);
    @(negedge clk);
    #1;
    check("restart_x1", int'(x_a), 1);
    check("restart_y1", int'(y_a), 0);

    repeat (40) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("en0_x",     int'(x_a),     0);
    check("en0_y",     int'(y_a),     0);
    check("en0_req",   int'(req_a),   0);
    check("en0_hs",    int'(hs_a),    1);
    check("en0_blank", int'(blank_a), 0);
    check("en0_x_b",   int'(x_b),     0);
    check("en0_hs_b",  int'(hs_b),    0);
    en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
